// File: rtl/decode_rename_pipe_if.sv
// Bundle of the rename stage's decode-side, ROB, writeback, commit and issue-side signals.
// The slave view belongs to the rename stage; the master view is whatever surrounds it.
interface decode_rename_pipe_if #(
    parameter int NSRC   = 2,
    parameter int XLEN   = 32,
    parameter int NREG_W = 5,
    parameter int ROB_W  = 4,
    parameter int FID_W  = 8
);
    logic                   flush;
    logic                   i_valid;
    logic                   i_ready;
    logic [FID_W-1:0]       i_fid;
    logic [ROB_W-1:0]       i_rob;
    logic [NSRC*NREG_W-1:0] i_src;
    logic                   i_dst_en;
    logic [NREG_W-1:0]      i_dst;
    logic [NSRC*ROB_W-1:0]  rob_raddr;
    logic [NSRC*XLEN-1:0]   rob_rdata;
    logic [NSRC-1:0]        rob_rready;
    logic                   wb_en;
    logic [ROB_W-1:0]       wb_rob;
    logic [XLEN-1:0]        wb_data;
    logic                   cm_en;
    logic [NREG_W-1:0]      cm_addr;
    logic [FID_W-1:0]       cm_fid;
    logic [XLEN-1:0]        cm_data;
    logic                   o_valid;
    logic                   o_ready;
    logic [FID_W-1:0]       o_fid;
    logic [ROB_W-1:0]       o_rob;
    logic                   o_dst_en;
    logic [NREG_W-1:0]      o_dst;
    logic [NSRC*ROB_W-1:0]  o_src_rob;
    logic [NSRC-1:0]        o_src_ready;
    logic [NSRC*XLEN-1:0]   o_src_value;

    modport slave (
        input  flush, i_valid, i_fid, i_rob, i_src, i_dst_en, i_dst,
        input  rob_rdata, rob_rready, wb_en, wb_rob, wb_data,
        input  cm_en, cm_addr, cm_fid, cm_data, o_ready,
        output i_ready, rob_raddr,
        output o_valid, o_fid, o_rob, o_dst_en, o_dst, o_src_rob, o_src_ready, o_src_value
    );

    modport master (
        output flush, i_valid, i_fid, i_rob, i_src, i_dst_en, i_dst,
        output rob_rdata, rob_rready, wb_en, wb_rob, wb_data,
        output cm_en, cm_addr, cm_fid, cm_data, o_ready,
        input  i_ready, rob_raddr,
        input  o_valid, o_fid, o_rob, o_dst_en, o_dst, o_src_rob, o_src_ready, o_src_value
    );
endinterface

// File: rtl/decode_rename_pipe.sv
// Register rename and operand fetch: owns the architectural regfile and RAT, resolves
// source operands with commit/writeback bypass, and holds one renamed instruction for issue.
module decode_rename_pipe #(
    parameter int NSRC   = 2,
    parameter int XLEN   = 32,
    parameter int NREG_W = 5,
    parameter int ROB_W  = 4,
    parameter int FID_W  = 8
) (
    input logic                 clk,
    input logic                 reset,
    decode_rename_pipe_if.slave bus
);
    localparam int NREG = 2 ** NREG_W;

    logic [XLEN-1:0]        r_regfile [NREG];
    logic [NREG-1:0]        r_ratValid;
    logic [ROB_W-1:0]       r_ratRob  [NREG];
    logic [FID_W-1:0]       r_ratFid  [NREG];

    logic                   r_oValid;
    logic [FID_W-1:0]       r_oFid;
    logic [ROB_W-1:0]       r_oRob;
    logic                   r_oDstEn;
    logic [NREG_W-1:0]      r_oDst;
    logic [NSRC*ROB_W-1:0]  r_oSrcRob;
    logic [NSRC-1:0]        r_oSrcReady;
    logic [NSRC*XLEN-1:0]   r_oSrcValue;

    logic                   w_iReady;
    logic                   w_accept;
    logic [NREG_W-1:0]      w_srcAddr [NSRC];
    logic [NSRC*ROB_W-1:0]  w_robRaddr;
    logic [NSRC*ROB_W-1:0]  w_srcRob;
    logic [NSRC-1:0]        w_srcReady;
    logic [NSRC*XLEN-1:0]   w_srcValue;

    assign w_iReady = !reset && !bus.flush && (!r_oValid || bus.o_ready);
    assign w_accept = bus.i_valid && w_iReady;

    assign bus.i_ready     = w_iReady;
    assign bus.rob_raddr   = w_robRaddr;
    assign bus.o_valid     = r_oValid;
    assign bus.o_fid       = r_oFid;
    assign bus.o_rob       = r_oRob;
    assign bus.o_dst_en    = r_oDstEn;
    assign bus.o_dst       = r_oDst;
    assign bus.o_src_rob   = r_oSrcRob;
    assign bus.o_src_ready = r_oSrcReady;
    assign bus.o_src_value = r_oSrcValue;

    // Operands see the RAT as it stood before this cycle's rename; commit bypass beats writeback.
    always_comb begin
        w_robRaddr = '0;
        w_srcRob   = '0;
        w_srcReady = '0;
        w_srcValue = '0;
        for (int s = 0; s < NSRC; s++) begin
            w_srcAddr[s] = bus.i_src[s*NREG_W +: NREG_W];
            w_robRaddr[s*ROB_W +: ROB_W] = r_ratRob[w_srcAddr[s]];
            if (r_ratValid[w_srcAddr[s]])
                w_srcRob[s*ROB_W +: ROB_W] = r_ratRob[w_srcAddr[s]];
            if (w_srcAddr[s] == '0) begin
                w_srcRob[s*ROB_W +: ROB_W] = '0;
                w_srcReady[s]              = 1'b1;
                w_srcValue[s*XLEN +: XLEN] = '0;
            end else if (r_ratValid[w_srcAddr[s]] && bus.cm_en && bus.cm_addr == w_srcAddr[s]
                         && bus.cm_fid == r_ratFid[w_srcAddr[s]]) begin
                w_srcReady[s]              = 1'b1;
                w_srcValue[s*XLEN +: XLEN] = bus.cm_data;
            end else if (r_ratValid[w_srcAddr[s]] && bus.wb_en
                         && bus.wb_rob == r_ratRob[w_srcAddr[s]]) begin
                w_srcReady[s]              = 1'b1;
                w_srcValue[s*XLEN +: XLEN] = bus.wb_data;
            end else if (r_ratValid[w_srcAddr[s]]) begin
                w_srcReady[s]              = bus.rob_rready[s];
                w_srcValue[s*XLEN +: XLEN] = bus.rob_rdata[s*XLEN +: XLEN];
            end else if (bus.cm_en && bus.cm_addr == w_srcAddr[s]) begin
                w_srcReady[s]              = 1'b1;
                w_srcValue[s*XLEN +: XLEN] = bus.cm_data;
            end else begin
                w_srcReady[s]              = 1'b1;
                w_srcValue[s*XLEN +: XLEN] = r_regfile[w_srcAddr[s]];
            end
        end
    end

    // Commits land in the regfile even while flushing; register 0 is never written.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++)
                r_regfile[r] <= '0;
        end else if (bus.cm_en && bus.cm_addr != '0) begin
            r_regfile[bus.cm_addr] <= bus.cm_data;
        end
    end

    // The fid guard keeps a stale commit from unmapping a newer producer; a same-cycle rename wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ratValid <= '0;
            for (int r = 0; r < NREG; r++) begin
                r_ratRob[r] <= '0;
                r_ratFid[r] <= '0;
            end
        end else if (bus.flush) begin
            r_ratValid <= '0;
        end else begin
            if (bus.cm_en && r_ratValid[bus.cm_addr] && r_ratFid[bus.cm_addr] == bus.cm_fid)
                r_ratValid[bus.cm_addr] <= 1'b0;
            if (w_accept && bus.i_dst_en && bus.i_dst != '0) begin
                r_ratValid[bus.i_dst] <= 1'b1;
                r_ratRob[bus.i_dst]   <= bus.i_rob;
                r_ratFid[bus.i_dst]   <= bus.i_fid;
            end
        end
    end

    // A stalled instruction keeps snooping writeback so its pending operands fill in place.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_oValid    <= 1'b0;
            r_oFid      <= '0;
            r_oRob      <= '0;
            r_oDstEn    <= 1'b0;
            r_oDst      <= '0;
            r_oSrcRob   <= '0;
            r_oSrcReady <= '0;
            r_oSrcValue <= '0;
        end else if (bus.flush) begin
            r_oValid <= 1'b0;
        end else if (w_accept) begin
            r_oValid    <= 1'b1;
            r_oFid      <= bus.i_fid;
            r_oRob      <= bus.i_rob;
            r_oDstEn    <= bus.i_dst_en;
            r_oDst      <= bus.i_dst;
            r_oSrcRob   <= w_srcRob;
            r_oSrcReady <= w_srcReady;
            r_oSrcValue <= w_srcValue;
        end else if (r_oValid && bus.o_ready) begin
            r_oValid <= 1'b0;
        end else if (r_oValid) begin
            for (int s = 0; s < NSRC; s++) begin
                if (!r_oSrcReady[s] && bus.wb_en && bus.wb_rob == r_oSrcRob[s*ROB_W +: ROB_W]) begin
                    r_oSrcReady[s]              <= 1'b1;
                    r_oSrcValue[s*XLEN +: XLEN] <= bus.wb_data;
                end
            end
        end
    end
endmodule
